// File: rtl/smart_store_pkg.sv
// Shared constants, state encoding and catalogue lookup for the smart-store cart ledger.
package smart_store_pkg;

  localparam int unsigned BC_W   = 16;
  localparam int unsigned COST_W = 10;
  localparam int unsigned N_PROD = 4;
  localparam int unsigned IDX_W  = 2;

  localparam logic [BC_W-1:0] BC_A = 16'hF0F0;
  localparam logic [BC_W-1:0] BC_B = 16'h5555;
  localparam logic [BC_W-1:0] BC_C = 16'hF00F;
  localparam logic [BC_W-1:0] BC_D = 16'h0F0F;

  localparam logic [COST_W-1:0] PRICE_A = 10'd50;
  localparam logic [COST_W-1:0] PRICE_B = 10'd30;
  localparam logic [COST_W-1:0] PRICE_C = 10'd20;
  localparam logic [COST_W-1:0] PRICE_D = 10'd15;

  typedef enum logic [1:0] {IDLE, SCANNED, COMMIT, WAIT_CLR} state_e;

  typedef struct packed {
    logic              known;
    logic [IDX_W-1:0]  idx;
    logic [COST_W-1:0] price;
  } prod_info_t;

  // Unknown barcodes map to index 0 with price 0 and known cleared.
  function automatic prod_info_t price_of(input logic [BC_W-1:0] bc);
    prod_info_t info;
    info = '0;
    case (bc)
      BC_A: begin info.known = 1'b1; info.idx = 2'd0; info.price = PRICE_A; end
      BC_B: begin info.known = 1'b1; info.idx = 2'd1; info.price = PRICE_B; end
      BC_C: begin info.known = 1'b1; info.idx = 2'd2; info.price = PRICE_C; end
      BC_D: begin info.known = 1'b1; info.idx = 2'd3; info.price = PRICE_D; end
      default: ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/remove_product_if.sv
// Cart ledger bus: add path, removal sensors and ledger outputs.
interface remove_product_if;
  import smart_store_pkg::*;

  logic              add_valid;
  logic [BC_W-1:0]   add_barcode;
  logic              object_out;
  logic              object_outside;
  logic [BC_W-1:0]   barcode;
  logic [COST_W-1:0] cost;
  logic [7:0]        item_count;
  logic              removed;
  logic              rm_err;
  logic              busy;

  modport master (
    output add_valid, add_barcode, object_out, object_outside, barcode,
    input  cost, item_count, removed, rm_err, busy
  );

  modport slave (
    input  add_valid, add_barcode, object_out, object_outside, barcode,
    output cost, item_count, removed, rm_err, busy
  );

endinterface

// File: rtl/product_lookup.sv
// Combinational barcode-to-catalogue decode.
module product_lookup
  import smart_store_pkg::*;
(
  input  logic [BC_W-1:0]   barcode,
  output logic              known,
  output logic [IDX_W-1:0]  idx,
  output logic [COST_W-1:0] price
);

  prod_info_t info;

  // Decode through the shared catalogue function.
  always_comb begin
    info = price_of(barcode);
  end

  assign known = info.known;
  assign idx   = info.idx;
  assign price = info.price;

endmodule

// File: rtl/remove_product.sv
// Cart ledger: per-product counters, running bill and two-phase removal FSM.
module remove_product
  import smart_store_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 4
) (
  input logic            clk,
  input logic            reset,
  remove_product_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned SUM_W = COST_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q [N_PROD];
  logic [CNT_W-1:0]  cnt_d [N_PROD];
  logic [COST_W-1:0] cost_q, cost_d;
  logic [7:0]        items_q, items_d;
  logic              removed_q, removed_d;
  logic              err_q, err_d;

  logic              do_commit, fsm_err, ledger_err, add_ok, rm_ok;
  logic [SUM_W-1:0]  sum;

  logic              add_known, rm_known;
  logic [IDX_W-1:0]  add_idx, rm_idx;
  logic [COST_W-1:0] add_price, rm_price;

  product_lookup u_add_lookup (
    .barcode (bus.add_barcode),
    .known   (add_known),
    .idx     (add_idx),
    .price   (add_price)
  );

  // Removal decodes the barcode latched at scan time, not the live scanner.
  product_lookup u_rm_lookup (
    .barcode (bc_q),
    .known   (rm_known),
    .idx     (rm_idx),
    .price   (rm_price)
  );

  // State, ledger and output pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bc_q      <= '0;
      timer_q   <= '0;
      cost_q    <= '0;
      items_q   <= '0;
      removed_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < N_PROD; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bc_q      <= bc_d;
      timer_q   <= timer_d;
      cost_q    <= cost_d;
      items_q   <= items_d;
      removed_q <= removed_d;
      err_q     <= err_d;
      for (int i = 0; i < N_PROD; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Removal FSM next state; exits take priority over the timeout.
  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    timer_d   = timer_q;
    do_commit = 1'b0;
    fsm_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.object_out && !bus.object_outside) begin
          bc_d    = bus.barcode;
          timer_d = '0;
          state_d = SCANNED;
        end
      end
      SCANNED: begin
        if (bus.object_out && bus.object_outside) begin
          fsm_err = 1'b1;
          state_d = IDLE;
        end else if (!bus.object_out && bus.object_outside) begin
          state_d = COMMIT;
        end else if (!bus.object_out && !bus.object_outside) begin
          state_d = IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          fsm_err = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_d   = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!bus.object_out && !bus.object_outside) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ledger update; add and commit checks both use pre-cycle counters so they net out.
  always_comb begin
    cnt_d      = cnt_q;
    items_d    = items_q;
    ledger_err = 1'b0;
    add_ok     = bus.add_valid && add_known && (cnt_q[add_idx] != CNT_MAX);
    rm_ok      = do_commit && rm_known && (cnt_q[rm_idx] != '0);
    if (bus.add_valid && !add_ok) ledger_err = 1'b1;
    if (do_commit && !rm_ok) ledger_err = 1'b1;
    if (add_ok) begin
      cnt_d[add_idx] = cnt_d[add_idx] + 1'b1;
      items_d        = items_d + 8'd1;
    end
    if (rm_ok) begin
      cnt_d[rm_idx] = cnt_d[rm_idx] - 1'b1;
      items_d       = items_d - 8'd1;
    end
    sum = {2'b00, cost_q}
        + (add_ok ? {2'b00, add_price} : '0)
        - (rm_ok  ? {2'b00, rm_price}  : '0);
    // Top bit set means the debit went below zero; next bit means it passed the cap.
    if (sum[SUM_W-1]) begin
      cost_d     = '0;
      ledger_err = 1'b1;
    end else if (sum[SUM_W-2]) begin
      cost_d     = '1;
      ledger_err = 1'b1;
    end else begin
      cost_d = sum[COST_W-1:0];
    end
    removed_d = rm_ok;
    err_d     = fsm_err | ledger_err;
  end

  assign bus.cost       = cost_q;
  assign bus.item_count = items_q;
  assign bus.removed    = removed_q;
  assign bus.rm_err     = err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_remove_product.sv
// Directed table-driven bench for the cart ledger.
module tb_remove_product;

  typedef struct {
    logic        add_valid;
    logic [15:0] add_barcode;
    logic        object_out;
    logic        object_outside;
    logic [15:0] barcode;
    logic [9:0]  cost;
    logic [7:0]  item_count;
    logic        removed;
    logic        rm_err;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  remove_product_if bus ();

  remove_product #(
    .TIMEOUT (16),
    .CNT_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic av, input logic [15:0] ab, input logic out,
                              input logic outs, input logic [15:0] bc, input int cost,
                              input int cnt, input logic rem, input logic err,
                              input logic busy);
    vec_t v;
    v.add_valid      = av;
    v.add_barcode    = ab;
    v.object_out     = out;
    v.object_outside = outs;
    v.barcode        = bc;
    v.cost           = 10'(cost);
    v.item_count     = 8'(cnt);
    v.removed        = rem;
    v.rm_err         = err;
    v.busy           = busy;
    return v;
  endfunction

  task automatic push(input logic av, input logic [15:0] ab, input logic out, input logic outs,
                      input logic [15:0] bc, input int cost, input int cnt, input logic rem,
                      input logic err, input logic busy);
    vecs.push_back(mk(av, ab, out, outs, bc, cost, cnt, rem, err, busy));
  endtask

  task automatic drive(input vec_t v);
    bus.add_valid      = v.add_valid;
    bus.add_barcode    = v.add_barcode;
    bus.object_out     = v.object_out;
    bus.object_outside = v.object_outside;
    bus.barcode        = v.barcode;
  endtask

  task automatic check(input string name, input vec_t v);
    n_vec++;
    if (bus.cost !== v.cost) begin
      n_miss++;
      $display("FAIL %s cost: got %0d want %0d", name, bus.cost, v.cost);
    end
    if (bus.item_count !== v.item_count) begin
      n_miss++;
      $display("FAIL %s item_count: got %0d want %0d", name, bus.item_count, v.item_count);
    end
    if (bus.removed !== v.removed) begin
      n_miss++;
      $display("FAIL %s removed: got %b want %b", name, bus.removed, v.removed);
    end
    if (bus.rm_err !== v.rm_err) begin
      n_miss++;
      $display("FAIL %s rm_err: got %b want %b", name, bus.rm_err, v.rm_err);
    end
    if (bus.busy !== v.busy) begin
      n_miss++;
      $display("FAIL %s busy: got %b want %b", name, bus.busy, v.busy);
    end
  endtask

  initial begin
    vec_t z;
    z = mk(0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
    drive(z);
    #1;
    check("reset_state", z);

    // Add two items, remove 5555h; outside held after commit must not re-trigger.
    push(0, 16'h0,    0, 0, 16'h0,     0, 0, 0, 0, 0);
    push(1, 16'hF0F0, 0, 0, 16'h0,    50, 1, 0, 0, 0);
    push(1, 16'h5555, 0, 0, 16'h0,    80, 2, 0, 0, 0);
    push(0, 16'h0,    1, 0, 16'h5555, 80, 2, 0, 0, 1);
    push(0, 16'h0,    0, 1, 16'h0,    80, 2, 0, 0, 1);
    push(0, 16'h0,    0, 1, 16'h0,    50, 1, 1, 0, 1);
    push(0, 16'h0,    0, 1, 16'h0,    50, 1, 0, 0, 1);
    push(0, 16'h0,    0, 0, 16'h0,    50, 1, 0, 0, 0);
    // Remove 0F0Fh that was never added.
    push(0, 16'h0,    1, 0, 16'h0F0F, 50, 1, 0, 0, 1);
    push(0, 16'h0,    0, 1, 16'h0,    50, 1, 0, 0, 1);
    push(0, 16'h0,    0, 0, 16'h0,    50, 1, 0, 1, 1);
    push(0, 16'h0,    0, 0, 16'h0,    50, 1, 0, 0, 0);
    // Scan then put back.
    push(0, 16'h0,    1, 0, 16'hF0F0, 50, 1, 0, 0, 1);
    push(0, 16'h0,    0, 0, 16'h0,    50, 1, 0, 0, 0);
    // Held scan times out on the 17th edge after entry.
    for (int i = 0; i < 16; i++) push(0, 16'h0, 1, 0, 16'hF0F0, 50, 1, 0, 0, 1);
    push(0, 16'h0,    1, 0, 16'hF0F0, 50, 1, 0, 1, 0);
    push(0, 16'h0,    0, 0, 16'h0,    50, 1, 0, 0, 0);
    // Sensor conflict in SCANNED.
    push(0, 16'h0,    1, 0, 16'hF0F0, 50, 1, 0, 0, 1);
    push(0, 16'h0,    1, 1, 16'h0,    50, 1, 0, 1, 0);
    push(0, 16'h0,    0, 0, 16'h0,    50, 1, 0, 0, 0);
    // Add F00Fh during the commit of F00Fh with counter 1: net zero.
    push(1, 16'hF00F, 0, 0, 16'h0,    70, 2, 0, 0, 0);
    push(0, 16'h0,    1, 0, 16'hF00F, 70, 2, 0, 0, 1);
    push(0, 16'h0,    0, 1, 16'h0,    70, 2, 0, 0, 1);
    push(1, 16'hF00F, 0, 1, 16'h0,    70, 2, 1, 0, 1);
    push(0, 16'h0,    0, 0, 16'h0,    70, 2, 0, 0, 0);
    // Counter for F00Fh is exactly 1: first removal succeeds, second is rejected.
    for (int k = 0; k < 2; k++) begin
      push(0, 16'h0, 1, 0, 16'hF00F, k == 0 ? 70 : 50, k == 0 ? 2 : 1, 0, 0, 1);
      push(0, 16'h0, 0, 1, 16'h0,    k == 0 ? 70 : 50, k == 0 ? 2 : 1, 0, 0, 1);
      push(0, 16'h0, 0, 0, 16'h0,    50, 1, k == 0, k == 1, 1);
      push(0, 16'h0, 0, 0, 16'h0,    50, 1, 0, 0, 0);
    end
    // Unknown barcode add.
    push(1, 16'h1234, 0, 0, 16'h0, 50, 1, 0, 1, 0);
    // Fill 0F0Fh to 15, then the 16th add is refused.
    for (int k = 1; k <= 15; k++) push(1, 16'h0F0F, 0, 0, 16'h0, 50 + 15 * k, 1 + k, 0, 0, 0);
    push(1, 16'h0F0F, 0, 0, 16'h0, 275, 16, 0, 1, 0);
    // Fill F0F0h from 1 to 15, then refused.
    for (int k = 1; k <= 14; k++) push(1, 16'hF0F0, 0, 0, 16'h0, 275 + 50 * k, 16 + k, 0, 0, 0);
    push(1, 16'hF0F0, 0, 0, 16'h0, 975, 30, 0, 1, 0);
    // Cost saturation at 1023.
    push(1, 16'h5555, 0, 0, 16'h0, 1005, 31, 0, 0, 0);
    push(1, 16'h5555, 0, 0, 16'h0, 1023, 32, 0, 1, 0);
    // Enter SCANNED ahead of the asynchronous reset.
    push(0, 16'h0,    1, 0, 16'hF0F0, 1023, 32, 0, 0, 1);

    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset between edges while SCANNED.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", z);
    @(negedge clk);
    reset = 1'b1;
    drive(mk(1, 16'hF0F0, 0, 0, 16'h0, 50, 1, 0, 0, 0));
    @(posedge clk);
    #1;
    check("post_reset_add", mk(1, 16'hF0F0, 0, 0, 16'h0, 50, 1, 0, 0, 0));
    drive(z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
